// File: rtl/tb_axi_mem.sv
// AXI4 slave memory model with INCR/FIXED/WRAP bursts, byte strobes and programmable read latency.
// Optional pseudo-random handshake throttling: define TB_AXI_MEM_BACKPRESSURE_EN.
module tb_axi_mem #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 36,
  parameter int ID_W       = 14,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LATENCY = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  logic [ID_W-1:0]     s_aw_id,
  input  logic [ADDR_W-1:0]   s_aw_addr,
  input  logic [7:0]          s_aw_len,
  input  logic [2:0]          s_aw_size,
  input  logic [1:0]          s_aw_burst,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [DATA_W-1:0]   s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb,
  input  logic                s_w_last,
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output logic [ID_W-1:0]     s_b_id,
  output logic [1:0]          s_b_resp,
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  input  logic [ID_W-1:0]     s_ar_id,
  input  logic [ADDR_W-1:0]   s_ar_addr,
  input  logic [7:0]          s_ar_len,
  input  logic [2:0]          s_ar_size,
  input  logic [1:0]          s_ar_burst,
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output logic [ID_W-1:0]     s_r_id,
  output logic [DATA_W-1:0]   s_r_data,
  output logic [1:0]          s_r_resp,
  output logic                s_r_last
);

  localparam int SW  = DATA_W / 8;
  localparam int OFF = $clog2(SW);

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  function automatic logic legal(input logic [2:0] size, input logic [1:0] burst,
                                 input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size == 3'(OFF)) && (burst != 2'b11) && ((burst != 2'b10) || wrap_ok);
  endfunction

  function automatic idx_t next_idx(input idx_t idx, input logic [1:0] burst,
                                    input logic [7:0] len);
    idx_t inc, mask;
    inc  = idx + idx_t'(1);
    mask = idx_t'(len[3:0]);
    case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Two-stage enable keeps the readys low through the first cycle after reset release.
  logic [1:0] live;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) live <= '0;
    else        live <= {live[0], 1'b1};
  end

  logic gate_aw, gate_w, gate_ar, r_hold;
`ifdef TB_AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  always_comb begin
    gate_aw = lfsr[0];
    gate_w  = lfsr[1];
    gate_ar = lfsr[2];
    r_hold  = lfsr[3];
  end
`else
  always_comb begin
    gate_aw = 1'b1;
    gate_w  = 1'b1;
    gate_ar = 1'b1;
    r_hold  = 1'b0;
  end
`endif

  // ---------------- write engine ----------------
  wstate_t         w_state, w_next;
  logic [ID_W-1:0] w_id;
  idx_t            w_idx;
  logic [7:0]      w_len, w_beat;
  logic [1:0]      w_burst;
  logic            w_legal, w_lasterr;
  logic            aw_hs, w_hs;

  always_comb begin
    s_aw_ready = live[1] && (w_state == W_IDLE) && gate_aw;
    s_w_ready  = (w_state == W_DATA) && gate_w;
    s_b_valid  = (w_state == W_RESP);
    s_b_id     = w_id;
    s_b_resp   = (s_b_valid && (!w_legal || w_lasterr)) ? 2'b10 : 2'b00;
    aw_hs      = s_aw_valid && s_aw_ready;
    w_hs       = s_w_valid && s_w_ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && (w_beat == w_len)) w_next = W_RESP;
      W_RESP:  if (s_b_ready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_id      <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_burst   <= '0;
      w_legal   <= 1'b0;
      w_lasterr <= 1'b0;
    end else if (aw_hs) begin
      w_id      <= s_aw_id;
      w_idx     <= s_aw_addr[OFF+DEPTH_LOG2-1:OFF];
      w_len     <= s_aw_len;
      w_beat    <= '0;
      w_burst   <= s_aw_burst;
      w_legal   <= legal(s_aw_size, s_aw_burst, s_aw_len);
      w_lasterr <= 1'b0;
    end else if (w_hs) begin
      w_beat <= w_beat + 8'd1;
      w_idx  <= next_idx(w_idx, w_burst, w_len);
      if (s_w_last != (w_beat == w_len)) w_lasterr <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs && w_legal) begin
      for (int unsigned i = 0; i < SW; i++) begin
        if (s_w_strb[i]) mem[w_idx][i*8 +: 8] <= s_w_data[i*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_t           r_state, r_next;
  logic [ID_W-1:0]   r_id;
  idx_t              r_idx, rd_idx;
  logic [7:0]        r_len, r_beat, r_cnt;
  logic [1:0]        r_burst;
  logic              r_legal, rd_ok, rd_load, r_up;
  logic [DATA_W-1:0] r_data;
  logic              ar_hs, r_hs, r_end;

  always_comb begin
    s_ar_ready = live[1] && (r_state == R_IDLE) && gate_ar;
    s_r_valid  = (r_state == R_DATA) && (r_up || !r_hold);
    s_r_id     = r_id;
    s_r_data   = r_data;
    s_r_resp   = ((r_state == R_DATA) && !r_legal) ? 2'b10 : 2'b00;
    s_r_last   = (r_state == R_DATA) && (r_beat == r_len);
    ar_hs      = s_ar_valid && s_ar_ready;
    r_hs       = s_r_valid && s_r_ready;
    r_end      = r_hs && (r_beat == r_len);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_cnt == 8'd1) r_next = R_DATA;
      R_DATA:  if (r_end) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // The data register is filled one edge ahead of each beat, so a same-edge write is not seen.
  always_comb begin
    rd_load = 1'b0;
    rd_idx  = r_idx;
    rd_ok   = r_legal;
    if (ar_hs && (RD_LATENCY == 0)) begin
      rd_load = 1'b1;
      rd_idx  = s_ar_addr[OFF+DEPTH_LOG2-1:OFF];
      rd_ok   = legal(s_ar_size, s_ar_burst, s_ar_len);
    end else if ((r_state == R_WAIT) && (r_cnt == 8'd1)) begin
      rd_load = 1'b1;
    end else if (r_hs && !r_end) begin
      rd_load = 1'b1;
      rd_idx  = next_idx(r_idx, r_burst, r_len);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_legal <= 1'b0;
      r_data  <= '0;
      r_up    <= 1'b0;
    end else begin
      r_up <= s_r_valid && !s_r_ready;
      if (rd_load) r_data <= rd_ok ? mem[rd_idx] : '0;
      if (ar_hs) begin
        r_id    <= s_ar_id;
        r_idx   <= s_ar_addr[OFF+DEPTH_LOG2-1:OFF];
        r_len   <= s_ar_len;
        r_beat  <= '0;
        r_cnt   <= 8'(RD_LATENCY);
        r_burst <= s_ar_burst;
        r_legal <= legal(s_ar_size, s_ar_burst, s_ar_len);
      end else begin
        if (r_state == R_WAIT) r_cnt <= r_cnt - 8'd1;
        if (r_hs) begin
          r_beat <= r_beat + 8'd1;
          if (!r_end) r_idx <= rd_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_tb_axi_mem.sv
// Directed bench for tb_axi_mem: a word-array memory model predicts every R/B beat, checked each cycle.
module tb_tb_axi_mem;
  localparam int DW = 64, AW = 20, IW = 4, DL = 6, LAT = 4, NW = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          s_aw_valid = 0, s_aw_ready;
  logic [IW-1:0] s_aw_id = 0;
  logic [AW-1:0] s_aw_addr = 0;
  logic [7:0]    s_aw_len = 0;
  logic [2:0]    s_aw_size = 0;
  logic [1:0]    s_aw_burst = 0;
  logic          s_w_valid = 0, s_w_ready;
  logic [DW-1:0] s_w_data = 0;
  logic [7:0]    s_w_strb = 0;
  logic          s_w_last = 0;
  logic          s_b_valid, s_b_ready = 1;
  logic [IW-1:0] s_b_id;
  logic [1:0]    s_b_resp;
  logic          s_ar_valid = 0, s_ar_ready;
  logic [IW-1:0] s_ar_id = 0;
  logic [AW-1:0] s_ar_addr = 0;
  logic [7:0]    s_ar_len = 0;
  logic [2:0]    s_ar_size = 0;
  logic [1:0]    s_ar_burst = 0;
  logic          s_r_valid, s_r_ready = 1;
  logic [IW-1:0] s_r_id;
  logic [DW-1:0] s_r_data;
  logic [1:0]    s_r_resp;
  logic          s_r_last;

  tb_axi_mem #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .DEPTH_LOG2(DL), .RD_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { logic [IW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rb_t;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bb_t;

  logic [63:0] mdl [NW];
  rb_t         exp_r[$];
  bb_t         exp_b[$];
  logic [63:0] rlog[$];
  logic [63:0] wd [64];
  logic [7:0]  ws [64];
  logic        wl [64];

  function automatic bit m_legal(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    if (size != 3'd3 || burst == 2'd3) return 0;
    if (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 0;
    return 1;
  endfunction

  function automatic int m_next(input int idx, input logic [1:0] burst, input logic [7:0] len);
    int n, base;
    n = int'(len) + 1;
    if (burst == 2'd0) return idx;
    if (burst == 2'd2) begin
      base = idx - (idx % n);
      return base + ((idx - base + 1) % n);
    end
    return (idx + 1) % NW;
  endfunction

  task automatic push_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int idx;
    bit ok;
    rb_t e;
    idx = int'(addr >> 3) % NW;
    ok  = m_legal(size, burst, len);
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.data = ok ? mdl[idx] : 64'h0;
      e.resp = ok ? 2'd0 : 2'd2;
      e.last = (b == int'(len));
      exp_r.push_back(e);
      idx = m_next(idx, burst, len);
    end
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int nbeats);
    int idx;
    if (!m_legal(size, burst, len)) return;
    idx = int'(addr >> 3) % NW;
    for (int b = 0; b < nbeats; b++) begin
      for (int i = 0; i < 8; i++) if (ws[b][i]) mdl[idx][i*8 +: 8] = wd[b][i*8 +: 8];
      idx = m_next(idx, burst, len);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  rb_t mon_e, held;
  bb_t mon_b;
  bit  stall_prev = 0;

  always @(negedge clock) begin
    if (!reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("r_stall_valid", 64'(s_r_valid), 64'd1);
        chk("r_stall_data", s_r_data, held.data);
        chk("r_stall_ctl", 64'({s_r_id, s_r_resp, s_r_last}), 64'({held.id, held.resp, held.last}));
      end
      if (s_r_valid && s_r_ready) begin
        if (exp_r.size() == 0) chk("r_spurious", 64'd1, 64'd0);
        else begin
          mon_e = exp_r.pop_front();
          chk("r_data", s_r_data, mon_e.data);
          chk("r_ctl", 64'({s_r_id, s_r_resp, s_r_last}), 64'({mon_e.id, mon_e.resp, mon_e.last}));
          rlog.push_back(s_r_data);
        end
      end
      stall_prev = s_r_valid && !s_r_ready;
      held.id = s_r_id; held.data = s_r_data; held.resp = s_r_resp; held.last = s_r_last;
      if (s_b_valid && s_b_ready) begin
        if (exp_b.size() == 0) chk("b_spurious", 64'd1, 64'd0);
        else begin
          mon_b = exp_b.pop_front();
          chk("b_resp", 64'({s_b_id, s_b_resp}), 64'({mon_b.id, mon_b.resp}));
        end
      end
    end
  end

  // ---------------- drivers (all start and end just after a rising edge) ----------------
  function automatic logic [63:0] outs();
    return 64'({s_aw_ready, s_w_ready, s_b_valid, s_b_id, s_b_resp,
                s_ar_ready, s_r_valid, s_r_id, s_r_resp, s_r_last});
  endfunction

  task automatic reset_seq();
    reset = 1'b0;
    #1;
    chk("rst_outs", outs(), 64'd0);
    chk("rst_rdata", s_r_data, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rel_outs", outs(), 64'd0);
    @(posedge clock); #1;
    chk("cycle1_outs", outs(), 64'd0);
    @(posedge clock); #1;
    chk("cycle2_readys", 64'({s_aw_ready, s_ar_ready}), 64'd3);
  endtask

  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_aw_valid = 1; s_aw_id = id; s_aw_addr = addr; s_aw_len = len; s_aw_size = size; s_aw_burst = burst;
    @(negedge clock);
    while (!s_aw_ready && n < 100) begin n++; @(negedge clock); end
    if (n >= 100) chk("aw_timeout", 64'd1, 64'd0);
    @(posedge clock); #1;
    s_aw_valid = 0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    s_w_valid = 1; s_w_data = d; s_w_strb = s; s_w_last = l;
    @(negedge clock);
    while (!s_w_ready && n < 100) begin n++; @(negedge clock); end
    if (n >= 100) chk("w_timeout", 64'd1, 64'd0);
    @(posedge clock); #1;
    s_w_valid = 0;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    bb_t e;
    int n = 0;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
    do_aw(id, addr, len, size, burst);
    for (int b = 0; b <= int'(len); b++) w_beat(wd[b], ws[b], wl[b]);
    @(negedge clock);
    chk("b_after_last_w", 64'(s_b_valid), 64'd1);
    @(posedge clock); #1;
    while (exp_b.size() != 0 && n < 100) begin n++; @(posedge clock); #1; end
    if (n >= 100) chk("b_timeout", 64'd1, 64'd0);
    model_write(addr, len, size, burst, int'(len) + 1);
  endtask

  task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit latchk);
    int n = 0;
    push_read(id, addr, len, size, burst);
    s_ar_valid = 1; s_ar_id = id; s_ar_addr = addr; s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
    @(negedge clock);
    while (!s_ar_ready && n < 100) begin n++; @(negedge clock); end
    if (n >= 100) chk("ar_timeout", 64'd1, 64'd0);
    @(posedge clock); #1;
    s_ar_valid = 0;
    if (latchk) begin
      n = 1;
      @(negedge clock);
      while (!s_r_valid && n < 300) begin n++; @(negedge clock); end
      chk("rd_latency", 64'(n), 64'(LAT + 1));
      @(posedge clock); #1;
    end
  endtask

  task automatic drain_r();
    int n = 0;
    while (exp_r.size() != 0 && n < 300) begin n++; @(posedge clock); #1; end
    if (n >= 300) chk("r_drain_timeout", 64'd1, 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    issue_ar(id, addr, len, size, burst, 1'b0);
    drain_r();
  endtask

  function automatic logic [63:0] rl(input int back);
    return rlog[rlog.size() - back];
  endfunction

  task automatic fill(input logic [63:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      wd[b] = base + 64'(b); ws[b] = 8'hFF; wl[b] = (b == n - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    reset_seq();

    // zero the whole memory so every later read is predictable
    for (int b = 0; b < 64; b++) begin wd[b] = 64'h0; ws[b] = 8'hFF; wl[b] = (b == 63); end
    do_write(4'd0, 20'h0, 8'd63, 3'd3, 2'd1, 2'd0);

    // INCR write/read through an aliased address
    fill(64'hA0, 4);
    do_write(4'd1, 20'h1000, 8'd3, 3'd3, 2'd1, 2'd0);
    issue_ar(4'd2, 20'h1000, 8'd3, 3'd3, 2'd1, 1'b1);
    drain_r();
    for (int i = 0; i < 4; i++) chk("incr_lit", rl(4 - i), 64'hA0 + 64'(i));

    // partial strobe on a zero word
    wd[0] = '1; ws[0] = 8'h01; wl[0] = 1;
    do_write(4'd3, 20'h50, 8'd0, 3'd3, 2'd1, 2'd0);
    do_read(4'd3, 20'h50, 8'd0, 3'd3, 2'd1);
    chk("strb_lit", rl(1), 64'h00000000000000FF);

    // WRAP from word 6 in a 4-word block, then an illegal WRAP length
    fill(64'hB4, 4);
    do_write(4'd4, 20'h20, 8'd3, 3'd3, 2'd1, 2'd0);
    do_read(4'd5, 20'h30, 8'd3, 3'd3, 2'd2);
    chk("wrap_lit0", rl(4), 64'hB6);
    chk("wrap_lit1", rl(3), 64'hB7);
    chk("wrap_lit2", rl(2), 64'hB4);
    chk("wrap_lit3", rl(1), 64'hB5);
    do_read(4'd6, 20'h30, 8'd2, 3'd3, 2'd2);
    for (int i = 1; i <= 3; i++) chk("wrap2_zero", rl(i), 64'h0);

    // early w_last: SLVERR but all beats land
    fill(64'hE0, 4);
    wl[1] = 1; wl[3] = 0;
    do_write(4'd7, 20'hF0, 8'd3, 3'd3, 2'd1, 2'd2);
    do_read(4'd7, 20'hF0, 8'd3, 3'd3, 2'd1);
    for (int i = 0; i < 4; i++) chk("lasterr_lit", rl(4 - i), 64'hE0 + 64'(i));

    // undersized write is discarded
    wd[0] = 64'hDEAD; ws[0] = 8'hFF; wl[0] = 1;
    do_write(4'd8, 20'h190, 8'd0, 3'd2, 2'd1, 2'd2);
    do_read(4'd8, 20'h190, 8'd0, 3'd3, 2'd1);
    chk("size_lit", rl(1), 64'h0);

    // r_ready stall across a 4-beat read
    s_r_ready = 0;
    issue_ar(4'd9, 20'h20, 8'd3, 3'd3, 2'd1, 1'b1);
    repeat (5) begin @(posedge clock); #1; end
    s_r_ready = 1;
    drain_r();
    chk("stall_lit", rl(1), 64'hB7);

    // simultaneous AW/AR; read of word 11 lands on the same edge as its write
    fill(64'h50, 4);
    do_write(4'd10, 20'h40, 8'd3, 3'd3, 2'd1, 2'd0);
    fill(64'h70, 4);
    fork
      do_write(4'd11, 20'h40, 8'd3, 3'd3, 2'd1, 2'd0);
      issue_ar(4'd12, 20'h58, 8'd0, 3'd3, 2'd1, 1'b1);
    join
    drain_r();
    chk("same_edge_old", rl(1), 64'h53);
    do_read(4'd12, 20'h58, 8'd0, 3'd3, 2'd1);
    chk("same_edge_new", rl(1), 64'h73);

    // reset after W beat 1 of 4
    fill(64'hC0, 4);
    do_aw(4'd13, 20'h140, 8'd3, 3'd3, 2'd1);
    w_beat(wd[0], ws[0], 1'b0);
    w_beat(wd[1], ws[1], 1'b0);
    model_write(20'h140, 8'd3, 3'd3, 2'd1, 2);
    reset_seq();
    do_read(4'd14, 20'h140, 8'd3, 3'd3, 2'd1);
    chk("rst_lit0", rl(4), 64'hC0);
    chk("rst_lit1", rl(3), 64'hC1);
    chk("rst_lit2", rl(2), 64'h0);
    chk("rst_lit3", rl(1), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
